// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the instruction-cycle controller: state encodings,
// address-register select values and generic enable levels.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_MEM        = 3'd4,
        ST_MEM_WAIT   = 3'd5,
        ST_WRITEBACK  = 3'd6,
        ST_HALT       = 3'd7
    } state_e;

    localparam logic DISABLE = 1'b0;
    localparam logic ENABLE  = 1'b1;

    localparam logic ADDRESS_SELECT_UPDATE = 1'b0;
    localparam logic ADDRESS_SELECT_HOLD   = 1'b1;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH_WAIT) || (s == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles without an acknowledge and flags when the
// configured timeout value has been reached.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear on wait-state entry, saturating increment otherwise.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (count_en_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/instr_cycle_controller.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// phase and writeback, with halt handling and a memory-acknowledge timeout.
module instr_cycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_ready,
    input  logic                de_mem_access,
    input  logic                de_mem_write_en,
    input  logic                de_reg_write_en,
    input  logic                de_reg_pc_write_en,
    input  logic                de_reg_lr_write_en,
    input  logic                de_reg_cpsr_write_en,
    input  logic                halt_req,
    output logic                fd_instr_latch_en,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addreg_mux_hold,
    output logic                reg_write_strobe,
    output logic                pc_write_strobe,
    output logic                lr_write_strobe,
    output logic                cpsr_write_strobe,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] retired_count,
    output logic [2:0]          state_o,
    output logic                halted,
    output logic                mem_timeout_err
);

    state_e                state_q, state_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic                  err_q, err_d;
    logic                  in_wait_s, expired_s, timeout_s;
    logic                  latch_s, mem_req_s, mem_we_s, hold_s;
    logic                  reg_s, pc_s, lr_s, cpsr_s, retire_s;

    assign in_wait_s = is_wait_state(state_q);
    // mem_ready on the expiry cycle wins over the timeout.
    assign timeout_s = in_wait_s && expired_s && !mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    ((state_q == ST_FETCH) || (state_q == ST_MEM)),
        .count_en_i (in_wait_s && !mem_ready),
        .expired_o  (expired_s)
    );

    // Next-state, counter and combinational output decode.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        err_d     = err_q;
        latch_s   = DISABLE;
        mem_req_s = DISABLE;
        mem_we_s  = DISABLE;
        hold_s    = ADDRESS_SELECT_UPDATE;
        reg_s     = DISABLE;
        pc_s      = DISABLE;
        lr_s      = DISABLE;
        cpsr_s    = DISABLE;
        retire_s  = DISABLE;
        case (state_q)
            ST_FETCH: begin
                mem_req_s = ENABLE;
                state_d   = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (timeout_s) begin
                    err_d   = ENABLE;
                    state_d = ST_HALT;
                end else if (mem_ready) begin
                    mem_req_s = ENABLE;
                    latch_s   = ENABLE;
                    state_d   = ST_DECODE;
                end else begin
                    mem_req_s = ENABLE;
                end
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = de_mem_access ? ST_MEM : ST_WRITEBACK;
            ST_MEM: begin
                mem_req_s = ENABLE;
                mem_we_s  = de_mem_write_en;
                hold_s    = ADDRESS_SELECT_HOLD;
                state_d   = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                hold_s = ADDRESS_SELECT_HOLD;
                if (timeout_s) begin
                    err_d   = ENABLE;
                    state_d = ST_HALT;
                end else begin
                    mem_req_s = ENABLE;
                    mem_we_s  = de_mem_write_en;
                    state_d   = mem_ready ? ST_WRITEBACK : ST_MEM_WAIT;
                end
            end
            ST_WRITEBACK: begin
                reg_s     = de_reg_write_en && !(de_mem_access && de_mem_write_en);
                pc_s      = de_reg_pc_write_en;
                lr_s      = de_reg_lr_write_en;
                cpsr_s    = de_reg_cpsr_write_en;
                retire_s  = ENABLE;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (!halt_req && !err_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State, retire counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    // Reset overrides the FETCH decode so nothing is requested while held.
    assign fd_instr_latch_en = latch_s   & rst_n;
    assign mem_req           = mem_req_s & rst_n;
    assign mem_we            = mem_we_s  & rst_n;
    assign addreg_mux_hold   = hold_s    & rst_n;
    assign reg_write_strobe  = reg_s     & rst_n;
    assign pc_write_strobe   = pc_s      & rst_n;
    assign lr_write_strobe   = lr_s      & rst_n;
    assign cpsr_write_strobe = cpsr_s    & rst_n;
    assign instr_retired     = retire_s  & rst_n;
    assign retired_count     = retired_q;
    assign state_o           = state_q;
    assign halted            = (state_q == ST_HALT);
    assign mem_timeout_err   = err_q;

endmodule

// File: tb/tb_instr_cycle_controller.sv
// Randomized scoreboard bench: per-instruction expectations derived from
// cycle-count rules, compared by a monitor on each retire pulse.
module tb_instr_cycle_controller;

    localparam int MT = 15;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic de_mem_access = 1'b0, de_mem_write_en = 1'b0, de_reg_write_en = 1'b0;
    logic de_reg_pc_write_en = 1'b0, de_reg_lr_write_en = 1'b0, de_reg_cpsr_write_en = 1'b0;
    logic halt_req = 1'b0;

    logic        fd_instr_latch_en, mem_req, mem_we, addreg_mux_hold;
    logic        reg_write_strobe, pc_write_strobe, lr_write_strobe, cpsr_write_strobe;
    logic        instr_retired, halted, mem_timeout_err;
    logic [31:0] retired_count;
    logic [2:0]  state_o;

    logic        w4_latch, w4_req, w4_we, w4_hold, w4_reg, w4_pc, w4_lr, w4_cpsr;
    logic        w4_ret, w4_halted, w4_err;
    logic [3:0]  w4_count;
    logic [2:0]  w4_state;

    instr_cycle_controller #(.MEM_TIMEOUT(MT), .RETIRE_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready),
        .de_mem_access(de_mem_access), .de_mem_write_en(de_mem_write_en),
        .de_reg_write_en(de_reg_write_en), .de_reg_pc_write_en(de_reg_pc_write_en),
        .de_reg_lr_write_en(de_reg_lr_write_en), .de_reg_cpsr_write_en(de_reg_cpsr_write_en),
        .halt_req(halt_req), .fd_instr_latch_en(fd_instr_latch_en), .mem_req(mem_req),
        .mem_we(mem_we), .addreg_mux_hold(addreg_mux_hold),
        .reg_write_strobe(reg_write_strobe), .pc_write_strobe(pc_write_strobe),
        .lr_write_strobe(lr_write_strobe), .cpsr_write_strobe(cpsr_write_strobe),
        .instr_retired(instr_retired), .retired_count(retired_count), .state_o(state_o),
        .halted(halted), .mem_timeout_err(mem_timeout_err)
    );

    instr_cycle_controller #(.MEM_TIMEOUT(MT), .RETIRE_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready),
        .de_mem_access(de_mem_access), .de_mem_write_en(de_mem_write_en),
        .de_reg_write_en(de_reg_write_en), .de_reg_pc_write_en(de_reg_pc_write_en),
        .de_reg_lr_write_en(de_reg_lr_write_en), .de_reg_cpsr_write_en(de_reg_cpsr_write_en),
        .halt_req(halt_req), .fd_instr_latch_en(w4_latch), .mem_req(w4_req),
        .mem_we(w4_we), .addreg_mux_hold(w4_hold),
        .reg_write_strobe(w4_reg), .pc_write_strobe(w4_pc),
        .lr_write_strobe(w4_lr), .cpsr_write_strobe(w4_cpsr),
        .instr_retired(w4_ret), .retired_count(w4_count), .state_o(w4_state),
        .halted(w4_halted), .mem_timeout_err(w4_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  strb;
        int unsigned cnt;
        int unsigned wb_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned n_ret = 0;
    logic        cur_store = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory responder: acknowledges after the queued number of idle wait cycles,
    // and toggles mem_ready randomly outside wait states.
    int  wcnt = 0, lat = 0;
    bit  in_wait = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst_n && (state_o == 3'd1 || state_o == 3'd5)) begin
            if (!in_wait) begin
                in_wait = 1'b1;
                wcnt = 0;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
            end
            mem_ready = (wcnt == lat);
            wcnt++;
        end else begin
            in_wait = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops an expectation on every retire pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_retired) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_strobes", {reg_write_strobe, pc_write_strobe, lr_write_strobe, cpsr_write_strobe}, mon_e.strb);
                    chk("retired_count", retired_count, mon_e.cnt);
                    chk("retired_count_w4", w4_count, mon_e.cnt % 16);
                    chk("wb_cycle", cyc, mon_e.wb_cyc);
                end
            end else begin
                chk("idle_strobes", {reg_write_strobe, pc_write_strobe, lr_write_strobe, cpsr_write_strobe}, 0);
            end
            if (mem_req && addreg_mux_hold) begin
                chk("data_mem_we", mem_we, cur_store);
            end else if (mem_req) begin
                chk("fetch_mem_we", mem_we, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int fl, input int ml, input bit acc, input bit wr,
                             input logic [3:0] en, input bit hlt);
        exp_t e;
        bit   seen;
        int   k;
        de_mem_access        = acc;
        de_mem_write_en      = wr;
        de_reg_write_en      = en[3];
        de_reg_pc_write_en   = en[2];
        de_reg_lr_write_en   = en[1];
        de_reg_cpsr_write_en = en[0];
        halt_req             = hlt;
        cur_store            = wr;
        lat_q.push_back(fl);
        if (acc) lat_q.push_back(ml);
        e.strb   = {en[3] & ~(acc & wr), en[2:0]};
        e.cnt    = n_ret;
        e.wb_cyc = cyc + 4 + fl + (acc ? ml + 2 : 0);
        exp_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = instr_retired;
        end
        if (!seen) chk("retire_wait_expired", 0, 1);
        n_ret++;
        step();
        if (hlt) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                chk("halted", halted, 1);
                chk("halt_state", state_o, 7);
                if (i == k - 1) halt_req = 1'b0;
                step();
            end
            chk("resume_fetch", state_o, 0);
        end
    endtask

    task automatic run_random();
        int fl, ml;
        fl = ($urandom_range(0, 7) == 0) ? MT : int'($urandom_range(0, 3));
        ml = ($urandom_range(0, 7) == 0) ? MT : int'($urandom_range(0, 4));
        run_instr(fl, ml, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {fd_instr_latch_en, mem_req, mem_we, addreg_mux_hold, reg_write_strobe,
                             pc_write_strobe, lr_write_strobe, cpsr_write_strobe, instr_retired}, 0);
        chk({tag, "_count"}, retired_count, 0);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_err"}, mem_timeout_err, 0);
    endtask

    initial begin
        int unsigned s;
        bit seen;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;

        run_instr(0, 0, 1'b0, 1'b0, 4'b1000, 1'b0);   // minimum non-memory latency
        run_instr(0, 3, 1'b1, 1'b1, 4'b1111, 1'b0);   // store, three idle wait cycles
        run_instr(0, 0, 1'b1, 1'b0, 4'b1010, 1'b1);   // load followed by halt
        for (int i = 0; i < 40; i++) run_random();

        // Fetch acknowledge never arrives: timeout, sticky error, HALT held.
        s = cyc;
        de_mem_access = 1'b0;
        halt_req = 1'b0;
        lat_q.push_back(MT + 1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = halted;
        end
        chk("timeout_halt_cycle", cyc, s + MT + 2);
        chk("timeout_err", mem_timeout_err, 1);
        chk("timeout_count", retired_count, n_ret);
        repeat (5) step();
        chk("timeout_stays_halted", state_o, 7);
        chk("timeout_err_sticky", mem_timeout_err, 1);

        rst_n = 1'b0;
        step();
        check_all_zero("reset2");
        rst_n = 1'b1;
        n_ret = 0;
        run_instr(1, 0, 1'b0, 1'b0, 4'b0110, 1'b0);
        run_instr(2, 1, 1'b1, 1'b0, 4'b1001, 1'b0);

        // Reset while the data phase is waiting for memory.
        de_mem_access = 1'b1;
        de_mem_write_en = 1'b0;
        de_reg_write_en = 1'b1;
        cur_store = 1'b0;
        lat_q.push_back(0);
        lat_q.push_back(10);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            seen = (state_o == 3'd5);
        end
        if (!seen) chk("reach_mem_wait", 0, 1);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        rst_n = 1'b1;
        n_ret = 0;
        for (int i = 0; i < 6; i++) run_random();

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cycle_controller.md
INSTR_CYCLE_CONTROLLER -- requirements
Module: instr_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum number of cycles to wait for mem_ready, range 1..255.
REQ-002 SHALL have parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 mem_ready  in  1  memory handshake acknowledge; read data is valid, or the write is accepted, in the cycle it is high.
REQ-007 de_mem_access  in  1  decoded instruction is a load or store.
REQ-008 de_mem_write_en  in  1  decoded access is a store; meaningful only when de_mem_access=1.
REQ-009 de_reg_write_en, de_reg_pc_write_en, de_reg_lr_write_en, de_reg_cpsr_write_en  in  1 each  decoder write requests.
REQ-010 halt_req  in  1  level request to stop at the next instruction boundary.
REQ-011 fd_instr_latch_en  out  1  loads the fetch/decode instruction register.
REQ-012 mem_req  out  1  memory request, held until mem_ready or timeout.
REQ-013 mem_we  out  1  write qualifier for mem_req.
REQ-014 addreg_mux_hold  out  1  freezes the address register during memory data phases.
REQ-015 reg_write_strobe, pc_write_strobe, lr_write_strobe, cpsr_write_strobe  out  1 each  single-cycle gated register-file strobes.
REQ-016 instr_retired  out  1  single-cycle pulse per completed instruction.
REQ-017 retired_count  out  RETIRE_W  count of retired instructions; wraps to 0.
REQ-018 state_o  out  3  current state encoding.
REQ-019 halted  out  1  high while in HALT.
REQ-020 mem_timeout_err  out  1  sticky error flag.

Function
REQ-021 State encodings SHALL be: FETCH=0, FETCH_WAIT=1, DECODE=2, EXECUTE=3, MEM=4, MEM_WAIT=5, WRITEBACK=6, HALT=7.
REQ-022 FETCH SHALL assert mem_req=1 and mem_we=0, then go to FETCH_WAIT.
REQ-023 FETCH_WAIT SHALL keep mem_req=1; on mem_ready it SHALL pulse fd_instr_latch_en in that same cycle and go to DECODE.
REQ-024 DECODE SHALL last exactly one cycle (decoder settle time) and then go to EXECUTE.
REQ-025 EXECUTE SHALL go to MEM if de_mem_access=1, otherwise to WRITEBACK.
REQ-026 MEM SHALL assert mem_req=1, mem_we=de_mem_write_en and addreg_mux_hold=1, then go to MEM_WAIT.
REQ-027 MEM_WAIT SHALL hold mem_req, mem_we and addreg_mux_hold; on mem_ready it SHALL go to WRITEBACK.
REQ-028 WRITEBACK SHALL pulse each strobe equal to its decoder enable (store: reg_write_strobe=0) and pulse instr_retired.
REQ-029 In WRITEBACK, retired_count SHALL increment by 1 and go to HALT if halt_req=1, otherwise to FETCH.
REQ-030 HALT SHALL drive all strobes and mem_req low; when halt_req=0 it SHALL go to FETCH on the next cycle.
REQ-031 halt_req SHALL have no effect in any state other than WRITEBACK and HALT; the current instruction always completes.
REQ-032 Minimum latency SHALL be: non-memory instruction 5 cycles (FETCH to WRITEBACK inclusive, mem_ready in the first FETCH_WAIT cycle); memory instruction 7 cycles.
REQ-033 An 8-bit wait counter SHALL clear on entry to FETCH_WAIT and to MEM_WAIT, and increment each cycle without mem_ready.
REQ-034 When the wait counter reaches MEM_TIMEOUT without mem_ready, the block SHALL set mem_timeout_err, drop mem_req and go to HALT without retiring.
REQ-035 mem_ready arriving on the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, not timeout.
REQ-036 mem_ready asserted outside FETCH_WAIT and MEM_WAIT SHALL be ignored.
REQ-037 mem_timeout_err SHALL clear only on reset; while it is set, HALT SHALL NOT exit.
REQ-038 All outputs other than retired_count, mem_timeout_err, state_o and halted SHALL be decoded combinationally from the state and inputs, with no latches.

Reset
REQ-039 While rst_n=0: state=FETCH, retired_count=0, wait counter=0, mem_timeout_err=0, halted=0.
REQ-040 While rst_n=0, all strobes, mem_req, mem_we, fd_instr_latch_en and addreg_mux_hold SHALL be 0, overriding the FETCH decode.
REQ-041 Reset asserted mid-instruction SHALL abandon the instruction with no strobe or retire pulse.
REQ-042 After the first rising clk edge following rst_n deassertion, the block SHALL begin FETCH.

Structure
REQ-043 State encodings, the ADDRESS_SELECT_* constants and the DISABLE/ENABLE constants SHALL live in a shared package, cpu_ctrl_pkg.
REQ-044 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer.

Verification
REQ-045 Non-memory instruction, mem_ready in the first wait cycle: WRITEBACK on cycle 5, reg_write_strobe=1 for 1 cycle, retired_count 0->1.
REQ-046 Store with de_mem_write_en=1, mem_ready after 3 wait cycles: mem_we=1 in MEM and MEM_WAIT, reg_write_strobe=0, instr_retired in cycle 10.
REQ-047 halt_req=1 raised during EXECUTE: instruction retires, state_o=7, halted=1; halt_req=0 -> FETCH next cycle.
REQ-048 mem_ready never asserts in FETCH_WAIT with MEM_TIMEOUT=15: after 15 cycles mem_timeout_err=1, HALT, retired_count unchanged; halt_req=0 -> remains HALT.
REQ-049 rst_n pulsed low in MEM_WAIT: all outputs 0 immediately, retired_count=0, no strobes.
REQ-050 retired_count preset near the maximum via 2^RETIRE_W retires (RETIRE_W=4 variant): wraps 15->0.
